alu_acc: RTL
============

# alu_acc

Parametrised, sequential accumulator ALU for the Simple-RISC core, executing the 3-bit ISA (HLT, SKZ, ADD, AND, XOR, LDA, STO, JMP) against an internal accumulator. The block holds the accumulator and zero flag in registers, accepts one operation per valid/ready handshake, and performs ADD as a multi-cycle slice-serial add. It sits between the instruction decoder (opcode plus memory operand) and the control sequencer, which consumes `skip`, `halted` and `res_valid`.

## Interface
- `WIDTH`, 8: data and accumulator width in bits.
- `SLICE`, 4: adder slice width. Must divide `WIDTH`. ADD takes `NS = WIDTH/SLICE` cycles.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `op_valid`  in  1  operation offered.
- `op_ready`  out  1  block can accept; high only in IDLE.
- `opcode`  in  3  000 HLT, 001 SKZ, 010 ADD, 011 AND, 100 XOR, 101 LDA, 110 STO, 111 JMP.
- `operand`  in  WIDTH  memory operand (inB).
- `resume`  in  1  leaves HALT.
- `acc`  out  WIDTH  registered accumulator.
- `is_zero`  out  1  registered; equals (`acc == 0`) at all times.
- `res_valid`  out  1  one-cycle pulse when an accepted operation completes.
- `skip`  out  1  one-cycle pulse; SKZ result.
- `halted`  out  1  high in HALT.
- `carry`  out  1  ADD carry-out; present only with `ALU_CARRY_EN`.

## Operation
- States: IDLE, ADD_BUSY, HALT.
- Accept: `op_valid && op_ready` at a rising edge. `opcode` and `operand` are sampled only at accept.
- IDLE, single-cycle operations (at the accept edge; state stays IDLE):
  - AND: `acc <= acc & operand`.
  - XOR: `acc <= acc ^ operand`.
  - LDA: `acc <= operand`.
  - STO, JMP: `acc` unchanged.
  - SKZ: `acc` unchanged; `skip <= is_zero` as sampled at accept.
  - HLT: `acc` unchanged; go to HALT and set `halted <= 1`.
- IDLE, ADD with `NS > 1`: latch `operand`, clear slice counter, go to ADD_BUSY.
- IDLE, ADD with `NS == 1`: complete at the accept edge, like a single-cycle operation.
- ADD_BUSY: each cycle adds slice k (bits `k*SLICE +: SLICE`) of `acc` and the latched operand, plus the internal carry, into a shadow register.
  - `acc` is not modified until the final slice.
  - On slice `NS-1`: `acc <= sum mod 2^WIDTH`, return to IDLE.
- HALT: `op_ready = 0`; `op_valid` is ignored. `resume` high at an edge leaves HALT for IDLE and clears `halted`. `resume` is ignored in every other state.
- `res_valid` pulses once per accepted operation, including HLT, SKZ, STO and JMP.
- Reset (any state, including mid-ADD): go to IDLE; `acc = 0`, `is_zero = 1`, `res_valid = 0`, `skip = 0`, `halted = 0`, `carry = 0`, `op_ready = 1`. A partial ADD is discarded.

## Timing
- Single-cycle operation accepted at edge E: `acc`, `is_zero`, `skip` and `res_valid` are valid in the cycle after E.
- `op_ready` stays high, so back-to-back accepts on consecutive edges are allowed.
- ADD accepted at edge E (`NS > 1`):
  - `op_ready` is low from E until the edge E+NS.
  - `acc` updates and `res_valid` pulses after edge E+NS.
  - `op_ready` is high again in that same cycle.
- HLT accepted at E: `halted` is high after E. `resume` at edge R gives `op_ready` high after R.
- `op_ready` is a combinational decode of the state only. It has no path from `op_valid`.

## Configuration
- `ALU_CARRY_EN` defined:
  - `carry` port exists.
  - `carry` is registered with the ADD carry-out at ADD completion.
  - AND, XOR and LDA clear `carry`; other operations hold it.
- `ALU_CARRY_EN` undefined: no `carry` port and no carry register. ADD wraps modulo 2^WIDTH.

## Test plan
- Reset: assert `rst_n=0` -> `acc=0x00`, `is_zero=1`, `op_ready=1`, `res_valid=0`, `halted=0`.
- Carry add (WIDTH=8, SLICE=4): LDA 0xF0, then ADD 0x20 ->
  - `op_ready` low for 2 cycles.
  - Then `acc=0x10`, `res_valid` pulses once, `carry=1` (with `ALU_CARRY_EN`).
- Zero and skip: with `acc=0x10`, AND 0x0F -> `acc=0x00`, `is_zero=1`; then SKZ -> `skip` high for exactly 1 cycle. XOR 0x01 then SKZ -> `skip` stays 0.
- Halt: HLT -> `halted=1`, `op_ready=0`. Hold `op_valid=1` with LDA 0xAA for 5 cycles -> `acc` unchanged. Pulse `resume` -> `op_ready=1` the next cycle, and LDA 0xAA then gives `acc=0xAA`.
- Reset mid-ADD: with `acc=0x55`, ADD 0x01, drop `rst_n` after 1 busy cycle -> `acc=0x00` immediately. After release, state is IDLE and no `res_valid` pulse occurs.
- Single-slice width (WIDTH=16, SLICE=16): LDA 0xFFFF, ADD 0x0001 -> completes in 1 cycle, `acc=0x0000`, `is_zero=1`, `carry=1`.

Source files
------------

// File: rtl/alu_acc.sv
// Accumulator ALU for the Simple-RISC core. ADD runs slice-serially over WIDTH/SLICE cycles.
// Define ALU_CARRY_EN to add the registered carry output.
module alu_acc #(
  parameter int WIDTH = 8,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] operand,
  input  logic             resume,
  output logic [WIDTH-1:0] acc,
  output logic             is_zero,
  output logic             res_valid,
  output logic             skip,
`ifdef ALU_CARRY_EN
  output logic             carry,
`endif
  output logic             halted
);

  // state    | meaning
  // IDLE     | accepting operations; single-cycle ops complete at accept
  // ADD_BUSY | slice-serial add in progress, acc held until the last slice
  // HALT     | stopped after HLT, waiting for resume
  typedef enum logic [1:0] {IDLE, ADD_BUSY, HALT} state_t;

  localparam int NS = WIDTH / SLICE;
  localparam int CW = (NS > 1) ? $clog2(NS) : 1;

  localparam logic [2:0] OP_HLT = 3'b000;
  localparam logic [2:0] OP_SKZ = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LDA = 3'b101;
  localparam logic [2:0] OP_STO = 3'b110;
  localparam logic [2:0] OP_JMP = 3'b111;

  state_t           state_q, state_nxt;
  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] opnd_q, opnd_nxt;
  logic [WIDTH-1:0] shadow_q, shadow_nxt;
  logic [CW-1:0]    cnt_q, cnt_nxt;
  logic             cin_q, cin_nxt;
  logic             res_nxt, skip_nxt, halted_nxt;
`ifdef ALU_CARRY_EN
  logic             carry_nxt;
`endif

  logic [31:0]      slice_base;
  logic [WIDTH-1:0] b_src;
  logic [SLICE-1:0] a_slice, b_slice, slice_s;
  logic             slice_c, cin_eff;
  logic [WIDTH-1:0] sum_word;

  // One slice adder serves both the single-slice IDLE add and the busy slices.
  always_comb begin
    slice_base = 32'(cnt_q) * 32'(SLICE);
    b_src      = (state_q == IDLE) ? operand : opnd_q;
    a_slice    = SLICE'(acc >> slice_base);
    b_slice    = SLICE'(b_src >> slice_base);
    cin_eff    = (state_q == ADD_BUSY) && cin_q;
    {slice_c, slice_s} = {1'b0, a_slice} + {1'b0, b_slice} + {{SLICE{1'b0}}, cin_eff};
    sum_word   = shadow_q | (WIDTH'(slice_s) << slice_base);
  end

  always_comb begin
    state_nxt  = state_q;
    acc_nxt    = acc;
    opnd_nxt   = opnd_q;
    shadow_nxt = shadow_q;
    cnt_nxt    = cnt_q;
    cin_nxt    = cin_q;
    res_nxt    = 1'b0;
    skip_nxt   = 1'b0;
    halted_nxt = halted;
    op_ready   = 1'b0;
`ifdef ALU_CARRY_EN
    carry_nxt  = carry;
`endif
    case (state_q)
      IDLE: begin
        op_ready = 1'b1;
        if (op_valid) begin
          res_nxt = 1'b1;
          case (opcode)
            OP_HLT: begin
              state_nxt  = HALT;
              halted_nxt = 1'b1;
            end
            OP_SKZ: skip_nxt = is_zero;
            OP_ADD: begin
              if (NS == 1) begin
                acc_nxt = sum_word;
`ifdef ALU_CARRY_EN
                carry_nxt = slice_c;
`endif
              end else begin
                res_nxt    = 1'b0;
                opnd_nxt   = operand;
                shadow_nxt = '0;
                cnt_nxt    = '0;
                cin_nxt    = 1'b0;
                state_nxt  = ADD_BUSY;
              end
            end
            OP_AND: begin
              acc_nxt = acc & operand;
`ifdef ALU_CARRY_EN
              carry_nxt = 1'b0;
`endif
            end
            OP_XOR: begin
              acc_nxt = acc ^ operand;
`ifdef ALU_CARRY_EN
              carry_nxt = 1'b0;
`endif
            end
            OP_LDA: begin
              acc_nxt = operand;
`ifdef ALU_CARRY_EN
              carry_nxt = 1'b0;
`endif
            end
            OP_STO, OP_JMP: ;
            default: ;
          endcase
        end
      end
      ADD_BUSY: begin
        shadow_nxt = sum_word;
        cin_nxt    = slice_c;
        if (cnt_q == CW'(NS - 1)) begin
          acc_nxt    = sum_word;
          res_nxt    = 1'b1;
          state_nxt  = IDLE;
          shadow_nxt = '0;
          cnt_nxt    = '0;
          cin_nxt    = 1'b0;
`ifdef ALU_CARRY_EN
          carry_nxt  = slice_c;
`endif
        end else begin
          cnt_nxt = cnt_q + CW'(1);
        end
      end
      HALT: begin
        if (resume) begin
          state_nxt  = IDLE;
          halted_nxt = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc       <= '0;
      is_zero   <= 1'b1;
      opnd_q    <= '0;
      shadow_q  <= '0;
      cnt_q     <= '0;
      cin_q     <= 1'b0;
      res_valid <= 1'b0;
      skip      <= 1'b0;
      halted    <= 1'b0;
`ifdef ALU_CARRY_EN
      carry     <= 1'b0;
`endif
    end else begin
      state_q   <= state_nxt;
      acc       <= acc_nxt;
      is_zero   <= (acc_nxt == '0);
      opnd_q    <= opnd_nxt;
      shadow_q  <= shadow_nxt;
      cnt_q     <= cnt_nxt;
      cin_q     <= cin_nxt;
      res_valid <= res_nxt;
      skip      <= skip_nxt;
      halted    <= halted_nxt;
`ifdef ALU_CARRY_EN
      carry     <= carry_nxt;
`endif
    end
  end

endmodule
